// File: rtl/updown_monitor.sv
// Qualifies the active-low decimal up/down count bus, classifies each step, keeps a tens digit and
// scans both digits onto a multiplexed active-low 7-segment display. Optional ERR flag: UPDOWN_MON_ERR_EN.
module updown_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int SCAN_DIV_BITS = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COUNT_N,
    output logic [6:0] SEG_N,
    output logic [1:0] DIG_N,
    output logic       DIR,
    output logic       STEP,
    output logic [3:0] TENS,
    output logic       ERR
);
    typedef enum logic {INIT, TRACK} state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [SYNC_STAGES:0]        prime_q;
    logic [3:0]                  cur;
    logic [3:0]                  curPrev_q;
    logic [3:0]                  cand_q;
    logic                        candValid_q;
    state_t                      state_q;
    logic [3:0]                  last_q;
    logic [3:0]                  tens_q;
    logic                        dir_q;
    logic                        step_q;
    logic [6:0]                  segN_q;
    logic [1:0]                  digN_q;
    logic [SCAN_DIV_BITS-1:0]    scan_q;
    logic                        candLegal;
    logic                        isUp;
    logic                        isDown;
    logic [3:0]                  lastPlus;
    logic [3:0]                  lastMinus;
    logic [3:0]                  tensInc;
    logic [3:0]                  tensDec;
    logic [3:0]                  shown;

    function automatic logic [6:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    segCode = 7'h3F;
            4'd1:    segCode = 7'h06;
            4'd2:    segCode = 7'h5B;
            4'd3:    segCode = 7'h4F;
            4'd4:    segCode = 7'h66;
            4'd5:    segCode = 7'h6D;
            4'd6:    segCode = 7'h7D;
            4'd7:    segCode = 7'h07;
            4'd8:    segCode = 7'h7F;
            4'd9:    segCode = 7'h6F;
            default: segCode = 7'h00;
        endcase
    endfunction

    assign cur = ~sync_q[SYNC_STAGES-1];

    // prime_q holds off qualification until the chain and compare flop contain real bus samples
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q      <= '0;
            prime_q     <= '0;
            curPrev_q   <= '0;
            cand_q      <= '0;
            candValid_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], COUNT_N};
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            curPrev_q   <= cur;
            candValid_q <= prime_q[SYNC_STAGES] && (cur == curPrev_q);
            if (prime_q[SYNC_STAGES] && (cur == curPrev_q)) begin
                cand_q <= cur;
            end
        end
    end

    always_comb begin
        candLegal = (cand_q <= 4'd9);
        lastPlus  = (last_q == 4'd9) ? 4'd0 : last_q + 4'd1;
        lastMinus = (last_q == 4'd0) ? 4'd9 : last_q - 4'd1;
        tensInc   = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        tensDec   = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        isUp      = (cand_q == lastPlus);
        isDown    = (cand_q == lastMinus);
        shown     = scan_q[SCAN_DIV_BITS-1] ? tens_q : last_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= INIT;
            last_q  <= 4'd0;
            tens_q  <= 4'd0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            segN_q  <= 7'h7F;
            digN_q  <= 2'b11;
        end else begin
            step_q <= 1'b0;
            if (candValid_q && candLegal) begin
                case (state_q)
                    INIT: begin
                        last_q  <= cand_q;
                        state_q <= TRACK;
                    end
                    TRACK: begin
                        // Illegal jumps still resynchronise last so the next step is judged from here
                        if (cand_q != last_q) begin
                            last_q <= cand_q;
                            if (isUp) begin
                                dir_q  <= 1'b1;
                                step_q <= 1'b1;
                                if (last_q == 4'd9) begin
                                    tens_q <= tensInc;
                                end
                            end else if (isDown) begin
                                dir_q  <= 1'b0;
                                step_q <= 1'b1;
                                if (last_q == 4'd0) begin
                                    tens_q <= tensDec;
                                end
                            end
                        end
                    end
                    default: state_q <= INIT;
                endcase
            end
            if (state_q == INIT) begin
                segN_q <= 7'h7F;
                digN_q <= 2'b11;
            end else begin
                segN_q <= ~segCode(shown);
                digN_q <= scan_q[SCAN_DIV_BITS-1] ? 2'b01 : 2'b10;
            end
        end
    end

`ifdef UPDOWN_MON_ERR_EN
    logic err_q;
    logic errEvent;

    always_comb begin
        errEvent = 1'b0;
        if (candValid_q) begin
            if (!candLegal) begin
                errEvent = 1'b1;
            end else if ((state_q == TRACK) && (cand_q != last_q) && !isUp && !isDown) begin
                errEvent = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | errEvent;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign SEG_N = segN_q;
    assign DIG_N = digN_q;
    assign DIR   = dir_q;
    assign STEP  = step_q;
    assign TENS  = tens_q;
endmodule

// File: tb/tb_updown_monitor.sv
// Self-checking bench for updown_monitor: random and directed bus sequences against a decimal step model.
module tb_updown_monitor;
    localparam int SYNC = 2;
    localparam int SCAN = 4;
`ifdef UPDOWN_MON_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] COUNT_N;
    logic [6:0] SEG_N;
    logic [1:0] DIG_N;
    logic       DIR;
    logic       STEP;
    logic [3:0] TENS;
    logic       ERR;

    int total = 0;
    int bad = 0;
    int lastM = 0;
    int tensM = 0;
    bit dirM = 1'b0;
    bit errM = 1'b0;
    bit trackM = 1'b0;
    logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    updown_monitor #(.SYNC_STAGES(SYNC), .SCAN_DIV_BITS(SCAN)) dut (
        .CLK(CLK), .RESET(RESET), .COUNT_N(COUNT_N), .SEG_N(SEG_N), .DIG_N(DIG_N),
        .DIR(DIR), .STEP(STEP), .TENS(TENS), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Decimal reference: step distance modulo 10 decides up/down/illegal
    task automatic modelApply(input int v, output int expPulses);
        int d;
        expPulses = 0;
        if (!trackM) begin
            if (v <= 9) begin
                lastM  = v;
                trackM = 1'b1;
            end else if (ERR_EN) begin
                errM = 1'b1;
            end
        end else if (v > 9) begin
            if (ERR_EN) errM = 1'b1;
        end else if (v != lastM) begin
            d = (v - lastM + 10) % 10;
            if (d == 1) begin
                expPulses = 1;
                dirM = 1'b1;
                if (v == 0) tensM = (tensM + 1) % 10;
            end else if (d == 9) begin
                expPulses = 1;
                dirM = 1'b0;
                if (v == 9) tensM = (tensM + 9) % 10;
            end else if (ERR_EN) begin
                errM = 1'b1;
            end
            lastM = v;
        end
    endtask

    task automatic modelReset();
        trackM = 1'b0;
        lastM  = 0;
        tensM  = 0;
        dirM   = 1'b0;
        errM   = 1'b0;
    endtask

    task automatic hold(input int v, input int cycles, output int pulses, output int firstAt);
        logic [3:0] vb;
        vb = 4'(v);
        COUNT_N = ~vb;
        pulses = 0;
        firstAt = -1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (STEP === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        COUNT_N = ~4'd3;
        repeat (3) @(negedge CLK);
        total++; if (SEG_N !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg: got %h expected 7f", SEG_N); end
        total++; if (DIG_N !== 2'b11) begin bad++; $display("[TB] FAIL reset_dig: got %b expected 11", DIG_N); end
        total++; if ({DIR, STEP, ERR} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {DIR, STEP, ERR}); end
        total++; if (TENS !== 4'd0) begin bad++; $display("[TB] FAIL reset_tens: got %0d expected 0", TENS); end
    endtask

    task automatic test_init_display();
        int p, f, e;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (DIG_N !== 2'b11 || SEG_N !== 7'h7F) begin bad++; $display("[TB] FAIL init_blank: got %b/%h expected 11/7f", DIG_N, SEG_N); end
        hold(3, 30, p, f);
        modelApply(3, e);
        total++; if (p !== e) begin bad++; $display("[TB] FAIL init_step: got %0d pulses expected %0d", p, e); end
        for (int i = 0; i < 40 && DIG_N !== 2'b10; i++) @(negedge CLK);
        total++; if (DIG_N !== 2'b10 || SEG_N !== ~segTab[lastM]) begin bad++; $display("[TB] FAIL init_ones: got %b/%h expected 10/%h", DIG_N, SEG_N, ~segTab[lastM]); end
        for (int i = 0; i < 40 && DIG_N !== 2'b01; i++) @(negedge CLK);
        total++; if (DIG_N !== 2'b01 || SEG_N !== ~segTab[tensM]) begin bad++; $display("[TB] FAIL init_tens: got %b/%h expected 01/%h", DIG_N, SEG_N, ~segTab[tensM]); end
    endtask

    task automatic test_up();
        int seq [8] = '{4, 5, 6, 7, 8, 9, 0, 1};
        int p, f, e;
        foreach (seq[k]) begin
            hold(seq[k], 50, p, f);
            modelApply(seq[k], e);
            total++; if (p !== e) begin bad++; $display("[TB] FAIL up_step v=%0d: got %0d expected %0d", seq[k], p, e); end
            if (e == 1) begin
                total++; if (f !== SYNC + 2) begin bad++; $display("[TB] FAIL up_latency v=%0d: got %0d expected %0d", seq[k], f, SYNC + 2); end
            end
            total++; if (DIR !== dirM || TENS !== tensM[3:0]) begin bad++; $display("[TB] FAIL up_dir_tens v=%0d: got %b/%0d expected %b/%0d", seq[k], DIR, TENS, dirM, tensM); end
        end
        for (int i = 0; i < 40 && DIG_N !== 2'b01; i++) @(negedge CLK);
        total++; if (DIG_N !== 2'b01 || SEG_N !== ~segTab[tensM]) begin bad++; $display("[TB] FAIL up_tens_disp: got %b/%h expected 01/%h", DIG_N, SEG_N, ~segTab[tensM]); end
    endtask

    task automatic test_down();
        int seq [12] = '{0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
        int p, f, e;
        foreach (seq[k]) begin
            hold(seq[k], 30, p, f);
            modelApply(seq[k], e);
            total++; if (p !== e) begin bad++; $display("[TB] FAIL down_step v=%0d: got %0d expected %0d", seq[k], p, e); end
            if (e == 1) begin
                total++; if (f !== SYNC + 2) begin bad++; $display("[TB] FAIL down_latency v=%0d: got %0d expected %0d", seq[k], f, SYNC + 2); end
            end
            total++; if (DIR !== dirM || TENS !== tensM[3:0]) begin bad++; $display("[TB] FAIL down_dir_tens v=%0d: got %b/%0d expected %b/%0d", seq[k], DIR, TENS, dirM, tensM); end
        end
    endtask

    task automatic test_illegal();
        int seq [3] = '{4, 7, 8};
        int p, f, e;
        foreach (seq[k]) begin
            hold(seq[k], 30, p, f);
            modelApply(seq[k], e);
            total++; if (p !== e) begin bad++; $display("[TB] FAIL illegal_step v=%0d: got %0d expected %0d", seq[k], p, e); end
            total++; if (DIR !== dirM || TENS !== tensM[3:0]) begin bad++; $display("[TB] FAIL illegal_dir_tens v=%0d: got %b/%0d expected %b/%0d", seq[k], DIR, TENS, dirM, tensM); end
            total++; if (ERR !== errM) begin bad++; $display("[TB] FAIL illegal_err v=%0d: got %b expected %b", seq[k], ERR, errM); end
        end
    endtask

    task automatic test_skew();
        int p, f, p1, f1, e;
        hold(3, 20, p, f);
        modelApply(3, e);
        total++; if (p !== e) begin bad++; $display("[TB] FAIL skew_setup: got %0d expected %0d", p, e); end
        hold(5, 1, p1, f1);
        hold(4, 20, p, f);
        modelApply(4, e);
        total++; if (p1 + p !== e) begin bad++; $display("[TB] FAIL skew_steps: got %0d expected %0d", p1 + p, e); end
        total++; if (f !== SYNC + 2) begin bad++; $display("[TB] FAIL skew_latency: got %0d expected %0d", f, SYNC + 2); end
        hold(15, 1, p1, f1);
        hold(4, 20, p, f);
        total++; if (p1 + p !== 0) begin bad++; $display("[TB] FAIL glitch_steps: got %0d expected 0", p1 + p); end
        total++; if (ERR !== errM) begin bad++; $display("[TB] FAIL glitch_err: got %b expected %b", ERR, errM); end
        for (int i = 0; i < 40 && DIG_N !== 2'b10; i++) @(negedge CLK);
        total++; if (DIG_N !== 2'b10 || SEG_N !== ~segTab[lastM]) begin bad++; $display("[TB] FAIL skew_ones: got %b/%h expected 10/%h", DIG_N, SEG_N, ~segTab[lastM]); end
    endtask

    task automatic test_random();
        int p, f, e, v, r;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) v = (lastM + 1) % 10;
            else if (r < 7) v = (lastM + 9) % 10;
            else v = $urandom_range(0, 15);
            hold(v, $urandom_range(8, 20), p, f);
            modelApply(v, e);
            total++; if (p !== e || (e == 1 && f !== SYNC + 2)) begin bad++; $display("[TB] FAIL rand_step v=%0d: got %0d@%0d expected %0d@%0d", v, p, f, e, SYNC + 2); end
            total++; if (DIR !== dirM || TENS !== tensM[3:0] || ERR !== errM) begin bad++; $display("[TB] FAIL rand_state v=%0d: got %b/%0d/%b expected %b/%0d/%b", v, DIR, TENS, ERR, dirM, tensM, errM); end
        end
    endtask

    task automatic test_reset_mid();
        int p, f, e, v, w;
        logic [3:0] vb;
        v = (lastM + 1) % 10;
        vb = 4'(v);
        COUNT_N = ~vb;
        p = 0;
        for (int i = 0; i < SYNC + 2; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (STEP === 1'b1) p++;
        end
        RESET = 1'b0;
        #1;
        total++; if (p !== 0) begin bad++; $display("[TB] FAIL rmid_early_step: got %0d expected 0", p); end
        total++; if (SEG_N !== 7'h7F || DIG_N !== 2'b11) begin bad++; $display("[TB] FAIL rmid_display: got %h/%b expected 7f/11", SEG_N, DIG_N); end
        total++; if ({DIR, STEP, ERR} !== 3'b000 || TENS !== 4'd0) begin bad++; $display("[TB] FAIL rmid_state: got %b/%0d expected 000/0", {DIR, STEP, ERR}, TENS); end
        hold(v, 5, p, f);
        total++; if (p !== 0) begin bad++; $display("[TB] FAIL rmid_step_in_reset: got %0d expected 0", p); end
        modelReset();
        w = $urandom_range(0, 9);
        vb = 4'(w);
        COUNT_N = ~vb;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (DIG_N !== 2'b11 || SEG_N !== 7'h7F) begin bad++; $display("[TB] FAIL rmid_blank: got %b/%h expected 11/7f", DIG_N, SEG_N); end
        hold(w, 30, p, f);
        modelApply(w, e);
        total++; if (p !== e || DIR !== dirM || TENS !== tensM[3:0]) begin bad++; $display("[TB] FAIL rmid_reinit: got %0d/%b/%0d expected %0d/%b/%0d", p, DIR, TENS, e, dirM, tensM); end
        for (int i = 0; i < 40 && DIG_N !== 2'b10; i++) @(negedge CLK);
        total++; if (DIG_N !== 2'b10 || SEG_N !== ~segTab[lastM]) begin bad++; $display("[TB] FAIL rmid_ones: got %b/%h expected 10/%h", DIG_N, SEG_N, ~segTab[lastM]); end
    endtask

    initial begin
        test_reset();
        test_init_display();
        test_up();
        test_down();
        test_illegal();
        test_skew();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_monitor.md
Name: updown_monitor

Overview:
- Reader for the active-low 4-bit decimal up/down count bus that the team's counters drive toward the LEDs.
- Samples the bus asynchronously and qualifies each new value.
- Classifies each accepted step as up, down or illegal, and keeps a tens digit from 9->0 / 0->9 wraps.
- Shows the two-digit result on a time-multiplexed active-low 7-segment display.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on COUNT_N (legal range 2..3).
SCAN_DIV_BITS, 16, width of the free-running scan divider; its MSB selects the digit.

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-low reset.
COUNT_N  input  4  active-low count from the counter, asynchronous to CLK; value = ~COUNT_N.
SEG_N  output  7  segments, active-low; bit0=a .. bit6=g.
DIG_N  output  2  digit enables, active-low; bit0=ones, bit1=tens.
DIR  output  1  direction of the last accepted step; 1=up, 0=down.
STEP  output  1  one-CLK pulse per accepted legal step.
TENS  output  4  tens digit, 0..9.
ERR  output  1  sticky illegal-step flag (see Optional Feature).

Behaviour:
- Reset (RESET=0, asynchronous) forces all outputs and state to their reset values:
  - SEG_N=7'h7F, DIG_N=2'b11, DIR=0, STEP=0, TENS=0, ERR=0.
  - Scan divider=0, state=INIT.
  - All synchroniser and qualifier flops are cleared.
- Release of RESET is taken synchronously to CLK.
- Input path:
  - COUNT_N passes through SYNC_STAGES flops, then is inverted to give `cur`.
  - `cur` is accepted as `cand` only when it is identical on two consecutive CLK cycles. This is the skew filter.
  - Latency: an input change sampled at edge 0 produces STEP high in the cycle after edge SYNC_STAGES+2.
- State INIT:
  - On the first qualified cand <= 9: last <= cand, TENS stays 0, no STEP, go to TRACK.
  - A cand > 9 is ignored and the block stays in INIT.
- State TRACK, acted on only when a qualified cand differs from `last`:
  - Up step: cand == last+1, or last==9 and cand==0.
    - Sets DIR=1 and pulses STEP.
    - On the 9->0 wrap, TENS increments, and TENS 9 wraps to 0.
  - Down step: cand == last-1, or last==0 and cand==9.
    - Sets DIR=0 and pulses STEP.
    - On the 0->9 wrap, TENS decrements, and TENS 0 wraps to 9.
  - Illegal jump (cand <= 9 but not +/-1 modulo 10):
    - last <= cand (resynchronise).
    - TENS and DIR unchanged, no STEP.
  - Cand > 9: ignored, last unchanged, no STEP.
  - A qualified cand equal to last: no action.
- Only one step is evaluated per qualified change. Back-to-back changes faster than the qualifier settles collapse to the final stable value and are classified against `last`.
- Display:
  - The scan divider free-runs from reset.
  - MSB=0: DIG_N=2'b10 and SEG_N shows `last`.
  - MSB=1: DIG_N=2'b01 and SEG_N shows TENS.
  - In INIT, DIG_N=2'b11 and SEG_N=7'h7F (blank).
  - Active-high abcdefg codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. SEG_N is the bitwise inverse.
  - All display outputs are registered; no combinational path from COUNT_N.
- Reset mid-operation: any step in flight is discarded, STEP does not pulse, and the block returns to INIT with a blank display.

Optional Feature:
- Macro: UPDOWN_MON_ERR_EN.
- Defined:
  - ERR sets the cycle after an illegal jump or a qualified cand > 9 in TRACK, or a qualified cand > 9 in INIT.
  - ERR is sticky until RESET.
  - While ERR=1, the decimal point is not used; the display is unchanged.
- Undefined: ERR is tied to 0 and no error logic is synthesised. Classification behaviour is otherwise identical.

Test Plan:
- Reset release, then COUNT_N=~4'd3 held -> after qualification DIG_N toggles between 2'b10 (SEG_N=~7'h4F) and 2'b01 (SEG_N=~7'h3F); STEP never pulses.
- From last=8: drive values 9, 0, 1 with 50 clocks between changes -> three STEP pulses, each SYNC_STAGES+2 cycles after its change; DIR=1; TENS 0->1 at the 9->0 step.
- From last=1, TENS=1: drive 0, 9 -> two STEP pulses, DIR=0, TENS=0 after 0->9. Continue down 8..0, 9 -> TENS wraps 0->9.
- From last=4: drive 7 -> no STEP, TENS/DIR unchanged, last=7; ERR=1 only with UPDOWN_MON_ERR_EN. Then drive 8 -> STEP with DIR=1.
- Bus skew: move COUNT_N 3->4 with bit changes 1 clock apart (transient 5 then 4), plus a glitch to 4'hF held for 1 clock -> exactly one STEP; value 15 is never accepted.
- RESET low mid-TRACK, within 1 cycle of a qualified change -> all outputs at reset values, no STEP; after release the block returns to INIT with a blank display until the bus qualifies.
